tap_delay_line: RTL and testbench
=================================

Name: tap_delay_line

Overview:
- Parametrised signed delay line / tap register: DEPTH stages of BUS_WIDTH-bit signed samples, shared enable, per-stage valid tracking, fill counter and fill state, registered sum of valid taps.
- Feeds FIR/convolution datapaths that need the last DEPTH samples plus a "window primed" indication.
- Successor to the single-stage enabled register: adds depth, bubbles, synchronous clear and accumulation.

Parameters:
- BUS_WIDTH, 8, sample width (signed two's complement).
- DEPTH, 3, number of stages (>=2).
- Derived localparam CNT_W = $clog2(DEPTH+1), fill-count width.
- Derived localparam SUM_W = BUS_WIDTH + $clog2(DEPTH), sum width (no overflow possible).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  shift enable.
- clr  in  1  synchronous clear; priority over en.
- d  in  BUS_WIDTH  signed input sample.
- d_valid  in  1  d carries a real sample (0 = bubble).
- taps  out  DEPTH*BUS_WIDTH  packed stage outputs; slice 0 = newest, slice DEPTH-1 = oldest.
- tap_valid  out  DEPTH  per-stage valid, same indexing.
- fill_cnt  out  CNT_W  number of set bits in tap_valid.
- fill_state  out  2  fill_state_t: EMPTY / PARTIAL / PRIMED.
- sum  out  SUM_W  signed sum of valid taps, registered.
- sum_valid  out  1  sum taken while PRIMED.

Behaviour:
- Reset (async, rst_n=0): taps=0, tap_valid=0, fill_cnt=0, fill_state=EMPTY, sum=0, sum_valid=0. Reset takes effect immediately, mid-operation included.
- Priority at each rising edge: clr > en > hold.
- clr=1: taps, tap_valid, fill_cnt, sum and sum_valid all go to 0 at that edge, regardless of en or d_valid.
- en=1, clr=0 (shift):
  - stage0 <= d; valid0 <= d_valid.
  - stage i <= stage i-1 for i=1..DEPTH-1, valid bits likewise.
  - The oldest stage is discarded.
  - A bubble (d_valid=0) still shifts. The stage0 data value then loads d but is marked invalid.
- Fill count on a shift: fill_cnt_next = fill_cnt + d_valid - valid[DEPTH-1].
  - Maintained incrementally, not by popcount.
  - Must always equal popcount(tap_valid); range 0..DEPTH, never wraps.
- en=0, clr=0: taps, tap_valid and fill_cnt hold, even while d and d_valid toggle.
- fill_state is combinational from fill_cnt: 0 -> EMPTY; DEPTH -> PRIMED; otherwise PARTIAL.
- sum / sum_valid, updated every non-reset, non-clr edge (independent of en):
  - sum <= sign-extended sum over i of (valid[i] ? tap[i] : 0), using current register contents.
  - sum_valid <= (fill_state == PRIMED).
  - Result: 1-cycle latency behind taps. While en=0 the sum re-registers the same value.
- Arithmetic: all samples sign-extended to SUM_W before adding. Worst case DEPTH*(-2^(BUS_WIDTH-1)) is representable.
- Simultaneous clr and en: clr wins, d is not captured.
- Bubble entering while PRIMED: fill_cnt drops to DEPTH-1, state PARTIAL. sum_valid drops one cycle later.

Decomposition:
- Package tap_delay_pkg:
  - typedef enum logic [1:0] fill_state_t {FILL_EMPTY=0, FILL_PARTIAL=1, FILL_PRIMED=2}.
  - Function sum_width(bus_width, depth).
- Sub-module delay_stage: one signed BUS_WIDTH data register plus valid bit.
  - Ports: async active-low reset, enable, sync clear.
  - Instantiated DEPTH times via generate.
- Counter, state decode and adder tree live in tap_delay_line.

Test Plan (BUS_WIDTH=8, DEPTH=3, SUM_W=10):
- Reset: assert rst_n=0 mid-shift with non-zero taps -> all outputs 0 immediately (before the next clock edge); fill_state=EMPTY.
- Fill: en=1, d_valid=1, d=5,-3,7 on three edges -> taps {7,-3,5}, fill_cnt 1,2,3, fill_state PRIMED after edge 3. On edge 4: sum=9, sum_valid=1.
- Extremes: push -128 x3 -> sum=-384 (10'h280), no overflow. Push 127 x3 -> sum=381.
- Bubble: from PRIMED {7,-3,5}, one edge with en=1, d_valid=0, d=100 -> tap_valid=3'b110, fill_cnt=2, PARTIAL. Next edge: sum=4, sum_valid=0.
- Hold: en=0 for 5 cycles while d and d_valid toggle -> taps, tap_valid and fill_cnt unchanged; sum constant.
- Clear: clr=1 together with en=1, d_valid=1, d=9 while PRIMED -> next edge: all taps 0, tap_valid=0, fill_cnt=0, sum=0, sum_valid=0; d=9 is not captured.

Source files
------------

// File: rtl/tap_delay_pkg.sv
// Shared types and width helpers for the tap delay line.
package tap_delay_pkg;

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_PRIMED  = 2'd2
    } fill_state_t;

    function automatic int clog2_int(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Enough headroom that DEPTH full-scale negative samples cannot overflow.
    function automatic int sum_width(input int bus_width, input int depth);
        return bus_width + clog2_int(depth);
    endfunction

endpackage

// File: rtl/tap_delay_line_if.sv
// Sample-in / window-out bundle of the tap delay line.
interface tap_delay_line_if #(
    parameter int BUS_WIDTH = 8,
    parameter int DEPTH     = 3
);
    import tap_delay_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = sum_width(BUS_WIDTH, DEPTH);

    logic                        en;
    logic                        clr;
    logic signed [BUS_WIDTH-1:0] d;
    logic                        d_valid;
    logic [DEPTH*BUS_WIDTH-1:0]  taps;
    logic [DEPTH-1:0]            tap_valid;
    logic [CNT_W-1:0]            fill_cnt;
    fill_state_t                 fill_state;
    logic signed [SUM_W-1:0]     sum;
    logic                        sum_valid;

    modport master (
        output en, clr, d, d_valid,
        input  taps, tap_valid, fill_cnt, fill_state, sum, sum_valid
    );

    modport slave (
        input  en, clr, d, d_valid,
        output taps, tap_valid, fill_cnt, fill_state, sum, sum_valid
    );

endinterface

// File: rtl/delay_stage.sv
// One signed sample register with its valid flag; clear beats enable.
module delay_stage #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        clr,
    input  logic signed [BUS_WIDTH-1:0] d,
    input  logic                        d_valid,
    output logic signed [BUS_WIDTH-1:0] q,
    output logic                        q_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (clr) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/tap_delay_line.sv
// DEPTH-stage signed delay line with valid tracking, fill status and a registered sum of valid taps.
module tap_delay_line
    import tap_delay_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int DEPTH     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    tap_delay_line_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = sum_width(BUS_WIDTH, DEPTH);

    logic [DEPTH-1:0][BUS_WIDTH-1:0] stage_d;
    logic [DEPTH-1:0][BUS_WIDTH-1:0] stage_q;
    logic [DEPTH-1:0]                stage_dv;
    logic [DEPTH-1:0]                stage_v;
    logic [CNT_W-1:0]                fill_cnt;
    fill_state_t                     fill_state;
    logic signed [SUM_W-1:0]         acc;
    logic signed [SUM_W-1:0]         sum;
    logic                            sum_valid;

    assign stage_d[0]  = bus.d;
    assign stage_dv[0] = bus.d_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i > 0) begin : g_link
            assign stage_d[i]  = stage_q[i-1];
            assign stage_dv[i] = stage_v[i-1];
        end
        delay_stage #(.BUS_WIDTH(BUS_WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.en),
            .clr     (bus.clr),
            .d       (stage_d[i]),
            .d_valid (stage_dv[i]),
            .q       (stage_q[i]),
            .q_valid (stage_v[i])
        );
    end

    // Incremental count: one sample in, the oldest one out; stays equal to popcount(stage_v).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fill_cnt <= '0;
        else if (bus.clr)
            fill_cnt <= '0;
        else if (bus.en)
            fill_cnt <= fill_cnt + CNT_W'(bus.d_valid) - CNT_W'(stage_v[DEPTH-1]);
    end

    always_comb begin
        fill_state = FILL_PARTIAL;
        if (fill_cnt == '0)
            fill_state = FILL_EMPTY;
        else if (fill_cnt == CNT_W'(DEPTH))
            fill_state = FILL_PRIMED;
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < DEPTH; i++)
            if (stage_v[i])
                acc = acc + {{(SUM_W-BUS_WIDTH){stage_q[i][BUS_WIDTH-1]}}, stage_q[i]};
    end

    // Sum follows the taps by one cycle and refreshes even while the line holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            sum_valid <= 1'b0;
        end else if (bus.clr) begin
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum       <= acc;
            sum_valid <= (fill_state == FILL_PRIMED);
        end
    end

    assign bus.taps       = stage_q;
    assign bus.tap_valid  = stage_v;
    assign bus.fill_cnt   = fill_cnt;
    assign bus.fill_state = fill_state;
    assign bus.sum        = sum;
    assign bus.sum_valid  = sum_valid;

endmodule

// File: tb/tb_tap_delay_line.sv
// Directed bench for tap_delay_line at BUS_WIDTH=8, DEPTH=3.
module tb_tap_delay_line;
    import tap_delay_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    tap_delay_line_if #(.BUS_WIDTH(8), .DEPTH(3)) bus ();

    tap_delay_line #(.BUS_WIDTH(8), .DEPTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic clr, input logic [7:0] d, input logic dv);
        bus.en      = en;
        bus.clr     = clr;
        bus.d       = d;
        bus.d_valid = dv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #3;
        total++;
        if (bus.taps !== 24'h0 || bus.tap_valid !== 3'b000 || bus.fill_cnt !== 2'd0)
            $display("FAIL reset_taps: got taps=%h v=%b cnt=%0d want 0/000/0", bus.taps, bus.tap_valid, bus.fill_cnt);
        else passed++;
        total++;
        if (bus.fill_state !== FILL_EMPTY || bus.sum !== 10'h0 || bus.sum_valid !== 1'b0)
            $display("FAIL reset_sum: got st=%0d sum=%h sv=%b want 0/000/0", bus.fill_state, bus.sum, bus.sum_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        drive(1'b1, 1'b0, 8'd5, 1'b1);
        step();
        total++;
        if (bus.fill_cnt !== 2'd1 || bus.fill_state !== FILL_PARTIAL)
            $display("FAIL fill_1: got cnt=%0d st=%0d want 1/1", bus.fill_cnt, bus.fill_state);
        else passed++;
        drive(1'b1, 1'b0, 8'hFD, 1'b1);
        step();
        total++;
        if (bus.fill_cnt !== 2'd2 || bus.fill_state !== FILL_PARTIAL)
            $display("FAIL fill_2: got cnt=%0d st=%0d want 2/1", bus.fill_cnt, bus.fill_state);
        else passed++;
        drive(1'b1, 1'b0, 8'd7, 1'b1);
        step();
        total++;
        if (bus.taps !== 24'h05FD07 || bus.tap_valid !== 3'b111)
            $display("FAIL fill_taps: got %h v=%b want 05fd07/111", bus.taps, bus.tap_valid);
        else passed++;
        total++;
        if (bus.fill_cnt !== 2'd3 || bus.fill_state !== FILL_PRIMED)
            $display("FAIL fill_3: got cnt=%0d st=%0d want 3/2", bus.fill_cnt, bus.fill_state);
        else passed++;
        total++;
        if (bus.sum !== 10'd2 || bus.sum_valid !== 1'b0)
            $display("FAIL fill_lag: got sum=%0d sv=%b want 2/0", bus.sum, bus.sum_valid);
        else passed++;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        total++;
        if (bus.sum !== 10'd9 || bus.sum_valid !== 1'b1)
            $display("FAIL fill_sum: got sum=%0d sv=%b want 9/1", bus.sum, bus.sum_valid);
        else passed++;
    endtask

    task automatic test_bubble();
        drive(1'b1, 1'b0, 8'd100, 1'b0);
        step();
        total++;
        if (bus.taps !== 24'hFD0764 || bus.tap_valid !== 3'b110)
            $display("FAIL bubble_taps: got %h v=%b want fd0764/110", bus.taps, bus.tap_valid);
        else passed++;
        total++;
        if (bus.fill_cnt !== 2'd2 || bus.fill_state !== FILL_PARTIAL || bus.sum_valid !== 1'b1)
            $display("FAIL bubble_cnt: got cnt=%0d st=%0d sv=%b want 2/1/1", bus.fill_cnt, bus.fill_state, bus.sum_valid);
        else passed++;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        total++;
        if (bus.sum !== 10'd4 || bus.sum_valid !== 1'b0)
            $display("FAIL bubble_sum: got sum=%0d sv=%b want 4/0", bus.sum, bus.sum_valid);
        else passed++;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'(8'h11 * (i + 1)), i[0]);
            step();
            total++;
            if (bus.taps !== 24'hFD0764 || bus.tap_valid !== 3'b110 || bus.fill_cnt !== 2'd2 || bus.sum !== 10'd4)
                $display("FAIL hold_%0d: got taps=%h v=%b cnt=%0d sum=%0d want fd0764/110/2/4",
                         i, bus.taps, bus.tap_valid, bus.fill_cnt, bus.sum);
            else passed++;
        end
    endtask

    task automatic test_clear();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1);
            step();
        end
        total++;
        if (bus.fill_state !== FILL_PRIMED || bus.taps !== 24'h010203)
            $display("FAIL clr_prime: got st=%0d taps=%h want 2/010203", bus.fill_state, bus.taps);
        else passed++;
        drive(1'b1, 1'b1, 8'd9, 1'b1);
        step();
        total++;
        if (bus.taps !== 24'h0 || bus.tap_valid !== 3'b000 || bus.fill_cnt !== 2'd0 || bus.fill_state !== FILL_EMPTY)
            $display("FAIL clr_taps: got taps=%h v=%b cnt=%0d st=%0d want 0/000/0/0",
                     bus.taps, bus.tap_valid, bus.fill_cnt, bus.fill_state);
        else passed++;
        total++;
        if (bus.sum !== 10'h0 || bus.sum_valid !== 1'b0)
            $display("FAIL clr_sum: got sum=%h sv=%b want 000/0", bus.sum, bus.sum_valid);
        else passed++;
        drive(1'b0, 1'b0, 8'd9, 1'b1);
        step();
        total++;
        if (bus.sum !== 10'h0 || bus.taps !== 24'h0)
            $display("FAIL clr_after: got sum=%h taps=%h want 000/000000", bus.sum, bus.taps);
        else passed++;
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h80, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        total++;
        if (bus.sum !== 10'h280 || bus.sum_valid !== 1'b1)
            $display("FAIL ext_neg: got sum=%h sv=%b want 280/1", bus.sum, bus.sum_valid);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h7F, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        total++;
        if (bus.sum !== 10'h17D || bus.sum_valid !== 1'b1)
            $display("FAIL ext_pos: got sum=%h sv=%b want 17d/1", bus.sum, bus.sum_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 8'h01, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.taps !== 24'h0 || bus.tap_valid !== 3'b000 || bus.fill_cnt !== 2'd0 || bus.fill_state !== FILL_EMPTY)
            $display("FAIL rst_mid_taps: got taps=%h v=%b cnt=%0d st=%0d want 0/000/0/0",
                     bus.taps, bus.tap_valid, bus.fill_cnt, bus.fill_state);
        else passed++;
        total++;
        if (bus.sum !== 10'h0 || bus.sum_valid !== 1'b0)
            $display("FAIL rst_mid_sum: got sum=%h sv=%b want 000/0", bus.sum, bus.sum_valid);
        else passed++;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_fill();
        test_bubble();
        test_hold();
        test_clear();
        test_extremes();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
